hyper_mvblck_frdram: RTL and testbench
======================================

# hyper_mvblck_frdram

Moves a block of words from DRAM into a selected LSAB section. It is the read-direction companion of the LSAB-to-DRAM block mover in the hyperfabric. The block issues column read requests to the MCU, tracks the MCU's fixed read latency with a valid-bit delay line, and strobes LSAB writes as the data arrives. The word datapath runs directly from MCU to LSAB; this block generates only addresses, requests and strobes.

## Interface
- READ_LATENCY, 4: cycles from a word's consume cycle to that word being valid on the MCU read bus (range 1..15).
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- LSAB_0_STOP..LSAB_3_STOP  in  1 each  section cannot accept another READ_LATENCY+1 words; must stop consuming.
- LSAB_WRITE  out  1  write strobe for the word currently on the MCU read bus.
- LSAB_SECTION  out  2  destination section, latched at issue.
- START_ADDRESS  in  12  first DRAM word address.
- COUNT_REQ  in  6  words requested, 0..63.
- SECTION  in  2  destination LSAB section.
- ISSUE  in  1  start request, sampled only in IDLE.
- COUNT_SENT  out  6  words actually written to LSAB, updated at completion.
- WORKING  out  1  busy flag, one-cycle-delayed copy of (state != IDLE).
- MCU_COLL_ADDRESS  out  12  column address, always even.
- MCU_REQUEST_ACCESS  out  1  one-cycle read request pulse.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Every cycle, latch SECTION into LSAB_SECTION, START_ADDRESS into track_addr, and COUNT_REQ into len_left and req_len.
  - If ISSUE=1, clear the write counter, set first=1, go to RUN. ISSUE is ignored in every other state.
- stop_n = (len_left != 0) && !LSAB_<LSAB_SECTION>_STOP. This is combinational.
- RUN, each cycle:
  - If stop_n, consume one word: track_addr+1 (12-bit wrap 0xFFF→0x000), len_left−1, and push 1 into the delay line.
  - Otherwise push 0 and go to DRAIN. Once RUN stops, it never resumes, even if STOP deasserts.
- Request rule: a consume cycle asserts MCU_REQUEST_ACCESS=1 and MCU_COLL_ADDRESS={track_addr[11:1],0} when track_addr[0]=0 or first=1. The first consume clears first.
  - MCU_REQUEST_ACCESS is 0 on every other cycle.
  - MCU_COLL_ADDRESS holds its value when no request is made.
- Delay line: a READ_LATENCY-deep shift register of valid bits. Its output drives LSAB_WRITE. Each LSAB_WRITE increments a 6-bit write counter.
- DRAIN: keep shifting 0s in. When the delay line is all-zero and LSAB_WRITE=0, load COUNT_SENT ← write counter and go to IDLE.
- COUNT_SENT always equals the number of LSAB_WRITE pulses in the operation, which equals req_len − len_left at exit from RUN.

## Timing
- Reset (RST low, asynchronous):
  - State goes to IDLE and the delay line clears.
  - LSAB_WRITE=0, LSAB_SECTION=0, COUNT_SENT=0, WORKING=0, MCU_COLL_ADDRESS=0, MCU_REQUEST_ACCESS=0.
  - A reset mid-operation discards all in-flight words; no LSAB_WRITE follows release.
- ISSUE high at edge n: RUN from edge n. The first consume is evaluated in cycle n+1, and its MCU_REQUEST_ACCESS is high after edge n+1.
- The word consumed at edge k has LSAB_WRITE high after edge k+READ_LATENCY. An uninterrupted burst yields back-to-back LSAB_WRITE pulses.
- WORKING rises after edge n+1 and falls one cycle after the return to IDLE.
- A new ISSUE is accepted in the first IDLE cycle.
- COUNT_REQ=0: RUN lasts one cycle with no requests, then DRAIN completes after READ_LATENCY cycles with COUNT_SENT=0.
- STOP already high at start: same behaviour as COUNT_REQ=0, with COUNT_SENT=0.
- STOP going high in the same cycle that len_left would reach 0: that word is not consumed.

## Test plan
- Plain burst: READ_LATENCY=4, START_ADDRESS=0x010, COUNT_REQ=4, STOP low.
  - Requests at 0x010 (consume 1) and 0x012 (consume 3).
  - LSAB_WRITE high for 4 consecutive cycles, starting 4 cycles after consume 1.
  - COUNT_SENT=4; WORKING drops afterwards.
- Odd start: START_ADDRESS=0x011, COUNT_REQ=3.
  - Requests at 0x010 (first word) and 0x012.
  - 3 LSAB_WRITE pulses; COUNT_SENT=3.
- Early stop: COUNT_REQ=10, SECTION=2, LSAB_2_STOP raised after the 2nd consume; LSAB_0_STOP toggles freely.
  - Exactly 2 LSAB_WRITE pulses; LSAB_SECTION=2; COUNT_SENT=2.
  - LSAB_0_STOP has no effect.
- Address wrap: START_ADDRESS=0xFFE, COUNT_REQ=4.
  - Requests at 0xFFE and 0x000.
  - COUNT_SENT=4.
- Zero and blocked starts: COUNT_REQ=0, and separately COUNT_REQ=5 with STOP high throughout.
  - No MCU_REQUEST_ACCESS, no LSAB_WRITE.
  - COUNT_SENT=0; WORKING high for about READ_LATENCY+1 cycles.
- Reset mid-burst: RST low for one cycle while 2 words are in flight.
  - All outputs 0 immediately; no LSAB_WRITE afterwards.
  - Next ISSUE with COUNT_REQ=2 completes normally with COUNT_SENT=2.

Source files
------------

// File: rtl/hyper_mvblck_frdram.sv
// DRAM-to-LSAB block mover: issues MCU column reads, tracks the fixed read
// latency with a valid-bit delay line and strobes LSAB writes as words land.
module hyper_mvblck_frdram #(
   parameter int unsigned READ_LATENCY = 4
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        lsab_0_stop_i,
   input  logic        lsab_1_stop_i,
   input  logic        lsab_2_stop_i,
   input  logic        lsab_3_stop_i,
   input  logic [11:0] start_address_i,
   input  logic [5:0]  count_req_i,
   input  logic [1:0]  section_i,
   input  logic        issue_i,
   output logic        lsab_write_o,
   output logic [1:0]  lsab_section_o,
   output logic [5:0]  count_sent_o,
   output logic        working_o,
   output logic [11:0] mcu_coll_address_o,
   output logic        mcu_request_access_o
);
   // state | meaning
   // IDLE  | tracking request inputs, waiting for issue
   // RUN   | consuming one word per cycle until length or stop ends it
   // DRAIN | no more consumes; waiting for in-flight words to be written
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   localparam logic [3:0] DRAIN_LD = 4'(READ_LATENCY - 1);

   state_e                  state_q, state_d;
   logic [11:0]             track_addr_q, track_addr_d;
   logic [5:0]              len_left_q, len_left_d;
   logic [1:0]              section_q, section_d;
   logic                    first_q, first_d;
   logic [READ_LATENCY-1:0] dl_q, dl_d, push_v;
   logic                    wr_q, wr_d;
   logic [5:0]              wcnt_q, wcnt_d;
   logic [5:0]              cs_q, cs_d;
   logic                    work_q;
   logic [11:0]             addr_q, addr_d;
   logic                    req_q, req_d;
   logic [3:0]              tmr_q, tmr_d;
   logic [3:0]              stop_v;
   logic                    stop_n;

   assign stop_v = {lsab_3_stop_i, lsab_2_stop_i, lsab_1_stop_i, lsab_0_stop_i};
   assign stop_n = (len_left_q != 6'd0) && !stop_v[section_q];

   always_comb begin
      state_d      = state_q;
      track_addr_d = track_addr_q;
      len_left_d   = len_left_q;
      section_d    = section_q;
      first_d      = first_q;
      wcnt_d       = wcnt_q + {5'd0, wr_q};
      cs_d         = cs_q;
      addr_d       = addr_q;
      req_d        = 1'b0;
      tmr_d        = tmr_q;
      push_v       = '0;
      case (state_q)
         IDLE: begin
            section_d    = section_i;
            track_addr_d = start_address_i;
            len_left_d   = count_req_i;
            if (issue_i) begin
               wcnt_d  = 6'd0;
               first_d = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (stop_n) begin
               track_addr_d = track_addr_q + 12'd1;
               len_left_d   = len_left_q - 6'd1;
               push_v[0]    = 1'b1;
               first_d      = 1'b0;
               // Odd first word still needs its even column fetched
               if (!track_addr_q[0] || first_q) begin
                  req_d  = 1'b1;
                  addr_d = {track_addr_q[11:1], 1'b0};
               end
            end else begin
               state_d = DRAIN;
               tmr_d   = DRAIN_LD;
            end
         end
         DRAIN: begin
            if (tmr_q != 4'd0) tmr_d = tmr_q - 4'd1;
            if ((tmr_q == 4'd0) && (dl_q == '0) && !wr_q) begin
               cs_d    = wcnt_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      dl_d = (dl_q << 1) | push_v;
      wr_d = dl_q[READ_LATENCY-1];
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         track_addr_q <= 12'd0;
         len_left_q   <= 6'd0;
         section_q    <= 2'd0;
         first_q      <= 1'b0;
         dl_q         <= '0;
         wr_q         <= 1'b0;
         wcnt_q       <= 6'd0;
         cs_q         <= 6'd0;
         work_q       <= 1'b0;
         addr_q       <= 12'd0;
         req_q        <= 1'b0;
         tmr_q        <= 4'd0;
      end else begin
         state_q      <= state_d;
         track_addr_q <= track_addr_d;
         len_left_q   <= len_left_d;
         section_q    <= section_d;
         first_q      <= first_d;
         dl_q         <= dl_d;
         wr_q         <= wr_d;
         wcnt_q       <= wcnt_d;
         cs_q         <= cs_d;
         work_q       <= (state_q != IDLE);
         addr_q       <= addr_d;
         req_q        <= req_d;
         tmr_q        <= tmr_d;
      end
   end

   assign lsab_write_o         = wr_q;
   assign lsab_section_o       = section_q;
   assign count_sent_o         = cs_q;
   assign working_o            = work_q;
   assign mcu_coll_address_o   = addr_q;
   assign mcu_request_access_o = req_q;
endmodule

// File: tb/tb_hyper_mvblck_frdram.sv
// Randomized and directed bench for hyper_mvblck_frdram against a per-operation
// timeline model derived from the request/latency rules.
module tb_hyper_mvblck_frdram;
   localparam int RL = 4;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic [3:0]  stop;
   logic [11:0] start_address;
   logic [5:0]  count_req;
   logic [1:0]  section;
   logic        issue;
   logic        lsab_write;
   logic [1:0]  lsab_section;
   logic [5:0]  count_sent;
   logic        working;
   logic [11:0] mcu_addr;
   logic        mcu_req;

   hyper_mvblck_frdram #(.READ_LATENCY(RL)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .lsab_0_stop_i(stop[0]), .lsab_1_stop_i(stop[1]),
      .lsab_2_stop_i(stop[2]), .lsab_3_stop_i(stop[3]),
      .start_address_i(start_address), .count_req_i(count_req),
      .section_i(section), .issue_i(issue),
      .lsab_write_o(lsab_write), .lsab_section_o(lsab_section),
      .count_sent_o(count_sent), .working_o(working),
      .mcu_coll_address_o(mcu_addr), .mcu_request_access_o(mcu_req));

   always #5 clk_i = ~clk_i;

   int          cyc, checks, failures;
   bit          chk_en;
   // current and previous operation, times are edge indices
   int          t_n, t_m, t_idle, p_n, p_idle, p_cs;
   logic [11:0] t_start, p_addr;
   logic [1:0]  s_cur, s_prev;
   bit          stop_pat [1:64];
   int          obs_wr, obs_work;
   logic [11:0] obs_addr [$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit word_req(input int j);
      logic [11:0] a;
      a = t_start + 12'(j - 1);
      return (j == 1) || !a[0];
   endfunction

   function automatic bit m_req(input int t);
      int i;
      i = t - t_n;
      return (i >= 1) && (i <= t_m) && word_req(i);
   endfunction

   function automatic logic [11:0] m_addr(input int t);
      int i;
      logic [11:0] a;
      i = t - t_n;
      if (i > t_m) i = t_m;
      for (int j = i; j >= 1; j--) begin
         if (word_req(j)) begin
            a = t_start + 12'(j - 1);
            return {a[11:1], 1'b0};
         end
      end
      return p_addr;
   endfunction

   function automatic bit m_wr(input int t);
      int i;
      i = t - t_n - RL;
      return (i >= 1) && (i <= t_m);
   endfunction

   function automatic bit m_work(input int t);
      return ((t >= t_n + 1) && (t <= t_idle)) || ((t >= p_n + 1) && (t <= p_idle));
   endfunction

   always @(negedge clk_i) begin
      if (chk_en) begin
         chk("mcu_request_access", int'(mcu_req), int'(m_req(cyc)));
         chk("mcu_coll_address", int'(mcu_addr), int'(m_addr(cyc)));
         chk("lsab_write", int'(lsab_write), int'(m_wr(cyc)));
         chk("working", int'(working), int'(m_work(cyc)));
         chk("count_sent", int'(count_sent), (cyc >= t_idle) ? t_m : p_cs);
         chk("lsab_section", int'(lsab_section), int'((cyc >= t_n) ? s_cur : s_prev));
         if (mcu_req) obs_addr.push_back(mcu_addr);
         if (lsab_write) obs_wr++;
         if (working) obs_work++;
      end
   end

   task automatic drive_stops();
      int i;
      i = cyc + 1 - t_n;
      for (int s = 0; s < 4; s++) stop[s] = ($urandom_range(0, 3) == 0);
      if (i >= 1 && i <= 64) stop[s_cur] = stop_pat[i];
   endtask

   task automatic tick();
      @(posedge clk_i);
      cyc++;
      #1;
      drive_stops();
   endtask

   task automatic model_reset();
      t_n = -1000; t_m = 0; t_idle = -1000; t_start = 12'd0;
      p_n = -1000; p_idle = -1000; p_cs = 0; p_addr = 12'd0;
      s_cur = 2'd0; s_prev = 2'd0;
   endtask

   task automatic issue_txn(input logic [11:0] a, input int c, input logic [1:0] s);
      while (cyc + 1 <= t_idle) tick();
      repeat ($urandom_range(0, 2)) tick();
      p_addr = m_addr(t_n + 64);
      p_cs = t_m; p_n = t_n; p_idle = t_idle; s_prev = s_cur;
      t_n = cyc + 1; t_start = a; s_cur = s; t_m = 0;
      for (int i = 1; i <= c; i++) begin
         if (stop_pat[i]) break;
         t_m++;
      end
      t_idle = (t_m == 0) ? t_n + RL + 1 : t_n + t_m + RL + 2;
      start_address = a; count_req = 6'(c); section = s; issue = 1'b1;
      drive_stops();
      tick();
      issue = 1'b0;
      start_address = 12'($urandom); count_req = 6'($urandom);
   endtask

   task automatic wait_done();
      while (cyc < t_idle + 1) tick();
   endtask

   task automatic directed(input string name, input logic [11:0] a, input int c,
                           input logic [1:0] s, input int e_wr, input int e_nreq,
                           input int e_r0, input int e_r1, input int e_work);
      obs_addr.delete(); obs_wr = 0; obs_work = 0;
      issue_txn(a, c, s);
      wait_done();
      chk({name, "_writes"}, obs_wr, e_wr);
      chk({name, "_nreq"}, obs_addr.size(), e_nreq);
      if (obs_addr.size() > 0 && e_nreq > 0) chk({name, "_req0"}, int'(obs_addr[0]), e_r0);
      if (obs_addr.size() > 1 && e_nreq > 1) chk({name, "_req1"}, int'(obs_addr[1]), e_r1);
      chk({name, "_count_sent"}, int'(count_sent), e_wr);
      chk({name, "_section"}, int'(lsab_section), int'(s));
      if (e_work >= 0) chk({name, "_work_cycles"}, obs_work, e_work);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0; checks = 0; failures = 0; chk_en = 1'b0;
      rst_n_i = 1'b0; stop = 4'd0; start_address = 12'd0; count_req = 6'd0;
      section = 2'd0; issue = 1'b0;
      model_reset();
      for (int i = 1; i <= 64; i++) stop_pat[i] = 1'b0;
      tick(); tick();
      chk("rst_write", int'(lsab_write), 0);
      chk("rst_req", int'(mcu_req), 0);
      chk("rst_addr", int'(mcu_addr), 0);
      chk("rst_count_sent", int'(count_sent), 0);
      chk("rst_working", int'(working), 0);
      chk("rst_section", int'(lsab_section), 0);
      #1 rst_n_i = 1'b1;
      chk_en = 1'b1;
      tick();

      directed("plain", 12'h010, 4, 2'd0, 4, 2, 'h010, 'h012, -1);
      directed("odd", 12'h011, 3, 2'd1, 3, 2, 'h010, 'h012, -1);
      directed("wrap", 12'hFFE, 4, 2'd3, 4, 2, 'hFFE, 'h000, -1);
      directed("zero", 12'h123, 0, 2'd1, 0, 0, 0, 0, RL + 1);
      for (int i = 1; i <= 64; i++) stop_pat[i] = 1'b1;
      directed("blocked", 12'h200, 5, 2'd2, 0, 0, 0, 0, RL + 1);
      for (int i = 1; i <= 64; i++) stop_pat[i] = (i >= 3);
      directed("early", 12'h040, 10, 2'd2, 2, 1, 'h040, 0, -1);
      for (int i = 1; i <= 64; i++) stop_pat[i] = (i >= 3);
      directed("lastword", 12'h080, 3, 2'd0, 2, 1, 'h080, 0, -1);

      // reset while two words are in flight
      for (int i = 1; i <= 64; i++) stop_pat[i] = 1'b0;
      issue_txn(12'h100, 10, 2'd1);
      while (cyc < t_n + 2) tick();
      #1 chk_en = 1'b0;
      rst_n_i = 1'b0;
      #1;
      chk("midrst_write", int'(lsab_write), 0);
      chk("midrst_req", int'(mcu_req), 0);
      chk("midrst_addr", int'(mcu_addr), 0);
      chk("midrst_count_sent", int'(count_sent), 0);
      chk("midrst_working", int'(working), 0);
      chk("midrst_section", int'(lsab_section), 0);
      section = 2'd0;
      tick();
      #1 rst_n_i = 1'b1;
      model_reset();
      chk_en = 1'b1;
      repeat (RL + 4) tick();
      directed("after_rst", 12'h300, 2, 2'd2, 2, 1, 'h300, 0, -1);

      for (int n = 0; n < 30; n++) begin
         int mode;
         mode = $urandom_range(0, 3);
         for (int i = 1; i <= 64; i++)
            stop_pat[i] = (mode == 0) ? 1'b0 : ($urandom_range(0, 15) == 0);
         issue_txn(12'($urandom), (n % 5 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 63),
                   2'($urandom));
         wait_done();
      end
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
